spi_flash_sequencer: RTL

Sequences M25P16-class SPI flash transactions for two on-chip requesters and owns the SPI pins: SPICLK, SPIMOSI, SPIMISO and chip_select.
- Round-robin arbitration between the two requesters.
- Supports RDID (0x9F, 3 ID bytes) and READ (0x03 + 24-bit address + N data bytes).
- Returns received bytes to the granted requester.
- Enforces the minimum chip-select-high time between transactions.

---
 rtl/spi_flash_sequencer.sv | 240 ++++++++++++++++++++++++
 1 files changed

// File: rtl/spi_flash_sequencer.sv
// spi_flash_sequencer: arbitrates two requesters onto one M25P16-class SPI
// flash and runs RDID / READ transactions in SPI mode 0 at clk/2.
// Every output is driven straight from a register.
module spi_flash_sequencer #(
   parameter int LEN_W          = 8,
   parameter int CS_HIGH_CYCLES = 5
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             req0,
   input  logic             cmd0,
   input  logic [23:0]      addr0,
   input  logic [LEN_W-1:0] len0,
   output logic             gnt0,
   output logic             rd_valid0,
   output logic             done0,
   input  logic             req1,
   input  logic             cmd1,
   input  logic [23:0]      addr1,
   input  logic [LEN_W-1:0] len1,
   output logic             gnt1,
   output logic             rd_valid1,
   output logic             done1,
   output logic [7:0]       rd_data,
   output logic             busy,
   output logic             SPICLK,
   output logic             SPIMOSI,
   input  logic             SPIMISO,
   output logic             chip_select
);

   localparam int CNT_W = (CS_HIGH_CYCLES > 1) ? $clog2(CS_HIGH_CYCLES) : 1;

   typedef enum logic [2:0] {
      S_IDLE, S_ZERO, S_SETUP, S_SHIFT, S_HOLD, S_DESEL
   } state_t;

   state_t           r_state, w_state_next;
   logic             r_port, w_port_next;
   logic             r_last_grant, w_last_grant_next;
   logic [31:0]      r_tx, w_tx_next;           // opcode + address, shifted out MSB first
   logic [2:0]       r_bit, w_bit_next;         // bit position inside the current byte
   logic [2:0]       r_hdr_left, w_hdr_left_next;   // header bytes still to send
   logic [LEN_W-1:0] r_data_left, w_data_left_next; // data bytes still to receive
   logic             r_last, w_last_next;       // final bit of the transaction is in flight
   logic [7:0]       r_rx, w_rx_next;
   logic [CNT_W-1:0] r_cnt, w_cnt_next;
   logic             r_gnt0, w_gnt0_next, r_gnt1, w_gnt1_next;
   logic             r_rdv0, w_rdv0_next, r_rdv1, w_rdv1_next;
   logic             r_done0, w_done0_next, r_done1, w_done1_next;
   logic [7:0]       r_rd_data, w_rd_data_next;
   logic             r_busy, w_busy_next;
   logic             r_sclk, w_sclk_next;
   logic             r_mosi, w_mosi_next;
   logic             r_cs, w_cs_next;

   // Arbitration: a tie goes to the port that was not granted last.
   logic             w_any_req, w_pick, w_cmd, w_zero_len;
   logic [23:0]      w_addr;
   logic [LEN_W-1:0] w_len;
   logic [7:0]       w_rx_byte;

   assign w_any_req  = req0 | req1;
   assign w_pick     = (req0 & req1) ? ~r_last_grant : req1;
   assign w_cmd      = w_pick ? cmd1 : cmd0;
   assign w_addr     = w_pick ? addr1 : addr0;
   assign w_len      = w_pick ? len1 : len0;
   assign w_zero_len = w_cmd && (w_len == '0);
   assign w_rx_byte  = {r_rx[6:0], SPIMISO};

   assign gnt0        = r_gnt0;
   assign gnt1        = r_gnt1;
   assign rd_valid0   = r_rdv0;
   assign rd_valid1   = r_rdv1;
   assign done0       = r_done0;
   assign done1       = r_done1;
   assign rd_data     = r_rd_data;
   assign busy        = r_busy;
   assign SPICLK      = r_sclk;
   assign SPIMOSI     = r_mosi;
   assign chip_select = r_cs;

   // State register; reset abandons any transaction with no DESEL wait.
   always_ff @(posedge clk) begin
      if (reset) r_state <= S_IDLE;
      else       r_state <= w_state_next;
   end

   // Next-state logic.
   always_comb begin
      w_state_next = r_state;
      case (r_state)
         S_IDLE:  if (w_any_req) w_state_next = w_zero_len ? S_ZERO : S_SETUP;
         S_ZERO:  w_state_next = S_IDLE;
         S_SETUP: w_state_next = S_SHIFT;
         S_SHIFT: if (r_sclk && r_last) w_state_next = S_HOLD;
         S_HOLD:  w_state_next = S_DESEL;
         S_DESEL: if (r_cnt == '0) w_state_next = S_IDLE;
         default: w_state_next = S_IDLE;
      endcase
   end

   // Output and datapath next values; pulses default low every cycle.
   always_comb begin
      w_port_next       = r_port;
      w_last_grant_next = r_last_grant;
      w_tx_next         = r_tx;
      w_bit_next        = r_bit;
      w_hdr_left_next   = r_hdr_left;
      w_data_left_next  = r_data_left;
      w_last_next       = r_last;
      w_rx_next         = r_rx;
      w_cnt_next        = r_cnt;
      w_gnt0_next       = 1'b0;
      w_gnt1_next       = 1'b0;
      w_rdv0_next       = 1'b0;
      w_rdv1_next       = 1'b0;
      w_done0_next      = 1'b0;
      w_done1_next      = 1'b0;
      w_rd_data_next    = r_rd_data;
      w_busy_next       = r_busy;
      w_sclk_next       = r_sclk;
      w_mosi_next       = r_mosi;
      w_cs_next         = r_cs;
      case (r_state)
         S_IDLE: begin
            if (w_any_req) begin
               w_port_next       = w_pick;
               w_last_grant_next = w_pick;
               w_gnt0_next       = ~w_pick;
               w_gnt1_next       = w_pick;
               w_busy_next       = 1'b1;
               // RDID sends zeros after the opcode while the ID bytes come back
               w_tx_next         = w_cmd ? {8'h03, w_addr} : {8'h9F, 24'h000000};
               w_hdr_left_next   = w_cmd ? 3'd4 : 3'd1;
               w_data_left_next  = w_cmd ? w_len : LEN_W'(3);
               w_bit_next        = 3'd0;
               w_last_next       = 1'b0;
            end
         end
         S_ZERO: begin
            w_done0_next = ~r_port;
            w_done1_next = r_port;
            w_busy_next  = 1'b0;
         end
         S_SETUP: begin
            w_cs_next   = 1'b0;
            w_sclk_next = 1'b0;
            w_mosi_next = r_tx[31];
         end
         S_SHIFT: begin
            if (!r_sclk) begin
               // rising SPICLK edge: MISO is captured on this same clk edge
               w_sclk_next = 1'b1;
               w_bit_next  = r_bit + 3'd1;
               if (r_hdr_left == 3'd0) begin
                  w_rx_next = w_rx_byte;
                  if (r_bit == 3'd7) begin
                     w_rd_data_next   = w_rx_byte;
                     w_rdv0_next      = ~r_port;
                     w_rdv1_next      = r_port;
                     w_data_left_next = r_data_left - LEN_W'(1);
                     w_last_next      = (r_data_left == LEN_W'(1));
                  end
               end else if (r_bit == 3'd7) begin
                  w_hdr_left_next = r_hdr_left - 3'd1;
               end
            end else begin
               // falling SPICLK edge: present the next MOSI bit
               w_sclk_next = 1'b0;
               if (r_last) begin
                  w_mosi_next = 1'b0;
               end else begin
                  w_mosi_next = r_tx[30];
                  w_tx_next   = {r_tx[30:0], 1'b0};
               end
            end
         end
         S_HOLD: begin
            w_cs_next    = 1'b1;
            w_done0_next = ~r_port;
            w_done1_next = r_port;
            w_cnt_next   = CNT_W'(CS_HIGH_CYCLES - 1);
         end
         S_DESEL: begin
            if (r_cnt == '0) w_busy_next = 1'b0;
            else             w_cnt_next  = r_cnt - CNT_W'(1);
         end
         default: ;
      endcase
   end

   // Datapath and output registers.
   always_ff @(posedge clk) begin
      if (reset) begin
         r_port       <= 1'b0;
         r_last_grant <= 1'b1;
         r_tx         <= '0;
         r_bit        <= '0;
         r_hdr_left   <= '0;
         r_data_left  <= '0;
         r_last       <= 1'b0;
         r_rx         <= '0;
         r_cnt        <= '0;
         r_gnt0       <= 1'b0;
         r_gnt1       <= 1'b0;
         r_rdv0       <= 1'b0;
         r_rdv1       <= 1'b0;
         r_done0      <= 1'b0;
         r_done1      <= 1'b0;
         r_rd_data    <= '0;
         r_busy       <= 1'b0;
         r_sclk       <= 1'b0;
         r_mosi       <= 1'b0;
         r_cs         <= 1'b1;
      end else begin
         r_port       <= w_port_next;
         r_last_grant <= w_last_grant_next;
         r_tx         <= w_tx_next;
         r_bit        <= w_bit_next;
         r_hdr_left   <= w_hdr_left_next;
         r_data_left  <= w_data_left_next;
         r_last       <= w_last_next;
         r_rx         <= w_rx_next;
         r_cnt        <= w_cnt_next;
         r_gnt0       <= w_gnt0_next;
         r_gnt1       <= w_gnt1_next;
         r_rdv0       <= w_rdv0_next;
         r_rdv1       <= w_rdv1_next;
         r_done0      <= w_done0_next;
         r_done1      <= w_done1_next;
         r_rd_data    <= w_rd_data_next;
         r_busy       <= w_busy_next;
         r_sclk       <= w_sclk_next;
         r_mosi       <= w_mosi_next;
         r_cs         <= w_cs_next;
      end
   end

endmodule
